// File: rtl/zx_kbd_pkg.sv
// zx_kbd_pkg -- shared definitions for the PS/2 to ZX Spectrum keyboard stage.
//   * parser FSM state enum
//   * Set-2 prefix bytes, the PANIC scancode and the Pause skip length
//   * Spectrum matrix row/column positions and composite-key indices
//   * keymap result type {kind, row, col} plus constructor helpers
package zx_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_SKIP
    } state_e;

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam logic [7:0] CODE_E1    = 8'hE1;
    localparam logic [7:0] CODE_PANIC = 8'h76;

    // Bytes that follow E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] SKIP_LEN = 3'd7;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;
    localparam int NUM_CMP  = 5;

    // Spectrum half-row numbers (row r is selected by A[8+r] = 0).
    localparam logic [2:0] ROW_CAPS_V = 3'd0;  // CAPS Z X C V
    localparam logic [2:0] ROW_A_G    = 3'd1;  // A S D F G
    localparam logic [2:0] ROW_Q_T    = 3'd2;  // Q W E R T
    localparam logic [2:0] ROW_1_5    = 3'd3;  // 1 2 3 4 5
    localparam logic [2:0] ROW_0_6    = 3'd4;  // 0 9 8 7 6
    localparam logic [2:0] ROW_P_Y    = 3'd5;  // P O I U Y
    localparam logic [2:0] ROW_ENT_H  = 3'd6;  // ENTER L K J H
    localparam logic [2:0] ROW_SPC_B  = 3'd7;  // SPACE SYM M N B

    localparam logic [2:0] COL_CAPS = 3'd0;
    localparam logic [2:0] COL_SYM  = 3'd1;

    // Composite-key flag indices into cmp.
    localparam logic [2:0] CMP_BKSP  = 3'd0;  // CAPS + 0
    localparam logic [2:0] CMP_LEFT  = 3'd1;  // CAPS + 5
    localparam logic [2:0] CMP_DOWN  = 3'd2;  // CAPS + 6
    localparam logic [2:0] CMP_UP    = 3'd3;  // CAPS + 7
    localparam logic [2:0] CMP_RIGHT = 3'd4;  // CAPS + 8

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_DIRECT,
        KEY_COMP,
        KEY_PANIC
    } key_kind_e;

    // For KEY_COMP the composite index travels in col.
    typedef struct packed {
        key_kind_e  kind;
        logic [2:0] row;
        logic [2:0] col;
    } key_t;

    function automatic key_t key_direct(input logic [2:0] row, input logic [2:0] col);
        key_t k;
        k.kind = KEY_DIRECT;
        k.row  = row;
        k.col  = col;
        return k;
    endfunction

    function automatic key_t key_comp(input logic [2:0] idx);
        key_t k;
        k.kind = KEY_COMP;
        k.row  = 3'd0;
        k.col  = idx;
        return k;
    endfunction

endpackage

// File: rtl/zx_keymap.sv
// zx_keymap -- combinational Set-2 scancode to Spectrum key table.
// Ports:
//   ext  in  1  byte was preceded by E0
//   code in  8  scancode byte
//   key  out    {kind, row, col}; unknown codes give KEY_NONE
module zx_keymap
    import zx_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_t       key
);

    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // key, so no latch is inferred for unlisted codes.
        key = '{kind: KEY_NONE, row: 3'd0, col: 3'd0};
        if (!ext) begin
            case (code)
                8'h12, 8'h59: key = key_direct(ROW_CAPS_V, COL_CAPS);
                8'h1A: key = key_direct(ROW_CAPS_V, 3'd1);  // Z
                8'h22: key = key_direct(ROW_CAPS_V, 3'd2);  // X
                8'h21: key = key_direct(ROW_CAPS_V, 3'd3);  // C
                8'h2A: key = key_direct(ROW_CAPS_V, 3'd4);  // V
                8'h1C: key = key_direct(ROW_A_G,    3'd0);  // A
                8'h1B: key = key_direct(ROW_A_G,    3'd1);  // S
                8'h23: key = key_direct(ROW_A_G,    3'd2);  // D
                8'h2B: key = key_direct(ROW_A_G,    3'd3);  // F
                8'h34: key = key_direct(ROW_A_G,    3'd4);  // G
                8'h15: key = key_direct(ROW_Q_T,    3'd0);  // Q
                8'h1D: key = key_direct(ROW_Q_T,    3'd1);  // W
                8'h24: key = key_direct(ROW_Q_T,    3'd2);  // E
                8'h2D: key = key_direct(ROW_Q_T,    3'd3);  // R
                8'h2C: key = key_direct(ROW_Q_T,    3'd4);  // T
                8'h16: key = key_direct(ROW_1_5,    3'd0);  // 1
                8'h1E: key = key_direct(ROW_1_5,    3'd1);  // 2
                8'h26: key = key_direct(ROW_1_5,    3'd2);  // 3
                8'h25: key = key_direct(ROW_1_5,    3'd3);  // 4
                8'h2E: key = key_direct(ROW_1_5,    3'd4);  // 5
                8'h45: key = key_direct(ROW_0_6,    3'd0);  // 0
                8'h46: key = key_direct(ROW_0_6,    3'd1);  // 9
                8'h3E: key = key_direct(ROW_0_6,    3'd2);  // 8
                8'h3D: key = key_direct(ROW_0_6,    3'd3);  // 7
                8'h36: key = key_direct(ROW_0_6,    3'd4);  // 6
                8'h4D: key = key_direct(ROW_P_Y,    3'd0);  // P
                8'h44: key = key_direct(ROW_P_Y,    3'd1);  // O
                8'h43: key = key_direct(ROW_P_Y,    3'd2);  // I
                8'h3C: key = key_direct(ROW_P_Y,    3'd3);  // U
                8'h35: key = key_direct(ROW_P_Y,    3'd4);  // Y
                8'h5A: key = key_direct(ROW_ENT_H,  3'd0);  // ENTER
                8'h4B: key = key_direct(ROW_ENT_H,  3'd1);  // L
                8'h42: key = key_direct(ROW_ENT_H,  3'd2);  // K
                8'h3B: key = key_direct(ROW_ENT_H,  3'd3);  // J
                8'h33: key = key_direct(ROW_ENT_H,  3'd4);  // H
                8'h29: key = key_direct(ROW_SPC_B,  3'd0);  // SPACE
                8'h14: key = key_direct(ROW_SPC_B,  COL_SYM);
                8'h3A: key = key_direct(ROW_SPC_B,  3'd2);  // M
                8'h31: key = key_direct(ROW_SPC_B,  3'd3);  // N
                8'h32: key = key_direct(ROW_SPC_B,  3'd4);  // B
                8'h66: key = key_comp(CMP_BKSP);
                CODE_PANIC: key.kind = KEY_PANIC;
                default: ;
            endcase
        end else begin
            case (code)
                8'h6B: key = key_comp(CMP_LEFT);
                8'h72: key = key_comp(CMP_DOWN);
                8'h75: key = key_comp(CMP_UP);
                8'h74: key = key_comp(CMP_RIGHT);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/zx_keymatrix.sv
// zx_keymatrix -- PS/2 Set-2 make/break parser, Spectrum 8x5 key matrix and
// port FEh readout.
// Ports:
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high
//   ps2_data_clk  in   1  one-cycle strobe, ps2_data valid
//   ps2_data      in   8  received scancode byte
//   A             in  16  Z80 address; A[15:8] half-row select, active low
//   D             out  8  registered {1,1,1,K4..K0}, pressed key reads 0
module zx_keymatrix
    import zx_kbd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_data_clk,
    input  logic [7:0]  ps2_data,
    input  logic [15:0] A,
    output logic [7:0]  D
);

    state_e     state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       lookup;
    logic       ext, rel;
    key_t       key;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] mat;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] eff;
    logic [NUM_CMP-1:0]                cmp;
    logic [NUM_COLS-1:0]               hit;

    // Port decoding on A[7:0] is done upstream in the read mux.
    logic unused_addr_low;
    assign unused_addr_low = ^A[7:0];

    // The prefix state of the byte being consumed decides ext/rel.
    assign ext = (state == ST_EXT) || (state == ST_EXTBRK);
    assign rel = (state == ST_BRK) || (state == ST_EXTBRK);

    zx_keymap u_keymap (
        .ext  (ext),
        .code (ps2_data),
        .key  (key)
    );

    // Parser next-state logic.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        lookup     = 1'b0;
        if (ps2_data_clk) begin
            case (state)
                ST_IDLE: begin
                    if (ps2_data == CODE_E0) begin
                        state_next = ST_EXT;
                    end else if (ps2_data == CODE_F0) begin
                        state_next = ST_BRK;
                    end else if (ps2_data == CODE_E1) begin
                        state_next = ST_SKIP;
                        skip_next  = SKIP_LEN;
                    end else begin
                        lookup = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_data == CODE_F0) begin
                        state_next = ST_EXTBRK;
                    end else if (ps2_data != CODE_E0) begin
                        lookup     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    lookup     = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_SKIP: begin
                    // Leave on the byte that brings the count to zero.
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_next  = 3'd0;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Composite keys overlay CAPS plus their partner key on top of the
    // direct matrix, so releasing one never clears a physically held key.
    always_comb begin
        eff = mat;
        if (cmp[CMP_BKSP]) begin
            eff[ROW_CAPS_V][COL_CAPS] = 1'b1;
            eff[ROW_0_6][0]           = 1'b1;
        end
        if (cmp[CMP_LEFT]) begin
            eff[ROW_CAPS_V][COL_CAPS] = 1'b1;
            eff[ROW_1_5][4]           = 1'b1;
        end
        if (cmp[CMP_DOWN]) begin
            eff[ROW_CAPS_V][COL_CAPS] = 1'b1;
            eff[ROW_0_6][4]           = 1'b1;
        end
        if (cmp[CMP_UP]) begin
            eff[ROW_CAPS_V][COL_CAPS] = 1'b1;
            eff[ROW_0_6][3]           = 1'b1;
        end
        if (cmp[CMP_RIGHT]) begin
            eff[ROW_CAPS_V][COL_CAPS] = 1'b1;
            eff[ROW_0_6][2]           = 1'b1;
        end
    end

    // A column reads pressed if any selected half-row has that key down.
    always_comb begin
        hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!A[8+r]) begin
                hit = hit | eff[r];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip_cnt <= 3'd0;
            // NOTE: the matrix is a plain register array (not a RAM), so it is
            // cleared by reset along with the rest of the state.
            mat      <= '0;
            cmp      <= '0;
            D        <= 8'hFF;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            D        <= {3'b111, ~hit};
            if (lookup) begin
                case (key.kind)
                    KEY_DIRECT: mat[key.row][key.col] <= !rel;
                    KEY_COMP:   cmp[key.col]          <= !rel;
                    KEY_PANIC: begin
                        if (!rel) begin
                            mat <= '0;
                            cmp <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zx_keymatrix.sv
// tb_zx_keymatrix -- directed self-checking bench for zx_keymatrix.
// Expected D values are queued as each read is set up and popped when the
// registered output is sampled on the falling edge.
module tb_zx_keymatrix;

    logic        clk;
    logic        reset;
    logic        ps2_data_clk;
    logic [7:0]  ps2_data;
    logic [15:0] A;
    logic [7:0]  D;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    zx_keymatrix dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_data_clk (ps2_data_clk),
        .ps2_data     (ps2_data),
        .A            (A),
        .D            (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        @(negedge clk);
        ps2_data_clk = 1'b0;
    endtask

    // Two strobes on consecutive clock cycles.
    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        ps2_data     = b0;
        ps2_data_clk = 1'b1;
        @(negedge clk);
        ps2_data     = b1;
        @(negedge clk);
        ps2_data_clk = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_d(input logic [7:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic compare_d();
        logic [7:0] e;
        string      t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: D=%h expected <none>", D);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (D === e) else begin
                errors++;
                $error("FAIL %s: D=%h expected %h", t, D, e);
            end
        end
    endtask

    // Drive A, queue the expectation, sample after the registering edge.
    task automatic read(input logic [15:0] addr, input logic [7:0] e, input string t);
        A = addr;
        expect_d(e, t);
        @(negedge clk);
        compare_d();
    endtask

    initial begin
        reset        = 1'b1;
        ps2_data_clk = 1'b0;
        ps2_data     = 8'h00;
        A            = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        read(16'hFEFE, 8'hFF, "reset_d");

        // Single key with exact latency: D moves 2 clocks after the strobe.
        A = 16'hFDFE;
        @(negedge clk);
        send(8'h1C);
        expect_d(8'hFF, "a_lat1");
        compare_d();
        @(negedge clk);
        expect_d(8'hFE, "a_lat2");
        compare_d();
        send(8'hF0); send(8'h1C);
        read(16'hFDFE, 8'hFF, "a_break");

        // Left arrow composite over a held Shift.
        send(8'h12);
        send(8'hE0); send(8'h6B);
        read(16'hFEFE, 8'hFE, "left_caps");
        read(16'hF7FE, 8'hEF, "left_5");
        send(8'hE0); send(8'hF0); send(8'h6B);
        read(16'hFEFE, 8'hFE, "shift_held");
        read(16'hF7FE, 8'hFF, "left_5_rel");
        send(8'hF0); send(8'h12);
        read(16'hFEFE, 8'hFF, "shift_rel");

        // Multi-row selection.
        send(8'h16); send(8'h1C);
        read(16'hFCFE, 8'hFE, "rows01");
        read(16'hF5FE, 8'hFE, "rows13");
        read(16'hF7FE, 8'hFE, "row3_1");
        read(16'hFFFE, 8'hFF, "no_row");
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h1C);
        read(16'h00FE, 8'hFF, "multi_rel");

        // Pause sequence must not touch the matrix.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        read(16'h7FFE, 8'hFE, "pause_space");
        send(8'hF0); send(8'h29);
        read(16'h7FFE, 8'hFF, "space_rel");

        // PANIC clears everything; its break is ignored.
        send(8'h1C); send(8'h66); send(8'h14);
        read(16'h00FE, 8'hFC, "pre_panic");
        read(16'hEFFE, 8'hFE, "bksp_0");
        send(8'h76);
        read(16'h00FE, 8'hFF, "panic");
        send(8'h1C);
        send(8'hF0); send(8'h76);
        read(16'hFDFE, 8'hFE, "panic_brk");

        // Typematic repeat and break of a key that is not held.
        send(8'h1C);
        send(8'hF0); send(8'h1D);
        read(16'hFDFE, 8'hFE, "typematic");
        read(16'hFBFE, 8'hFF, "brk_unheld");
        send(8'hF0); send(8'h1C);
        read(16'hFDFE, 8'hFF, "a_rel2");

        // Back-to-back strobes.
        send_pair(8'hE0, 8'h74);
        read(16'hFEFE, 8'hFE, "right_caps");
        read(16'hEFFE, 8'hFB, "right_8");
        send_pair(8'hE0, 8'hF0);
        send(8'h74);
        read(16'h00FE, 8'hFF, "right_rel");

        // Reset mid-sequence: following 75 is plain (keypad 8, no key).
        send(8'hE0);
        pulse_reset();
        send(8'h75);
        read(16'hEFFE, 8'hFF, "mid_rst_row4");
        read(16'hFEFE, 8'hFF, "mid_rst_caps");

        // Strobe coincident with reset is dropped.
        @(negedge clk);
        reset        = 1'b1;
        ps2_data     = 8'h1C;
        ps2_data_clk = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        ps2_data_clk = 1'b0;
        read(16'hFDFE, 8'hFF, "rst_drop");
        send(8'h1C);
        read(16'hFDFE, 8'hFE, "after_drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
